// File: rtl/verlet_step_scheduler.sv
// verlet_step_scheduler
//
// Runs one Verlet step over all particles. For each particle it reads the
// current and previous position from particle RAM, presents them to the
// shared combinational integrator, registers the integrated result with a
// floor clamp on y, and writes it back. The old current position becomes the
// new previous position.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                one-cycle step request, only accepted in IDLE
//   num_particles        particle count, captured when start is accepted
//   busy, done           step in progress / one-cycle completion pulse
//   step_count           completed steps, wraps modulo 2^STEP_W
//   rd_en, rd_addr       RAM read strobe and index
//   rd_x/y/px/py         RAM read data, valid one cycle after rd_en
//   vi_x/y/px/py         registered integrator operands
//   vi_int_x/y           integrator results (combinational from vi_*)
//   wr_en, wr_ready      write request / arbiter grant
//   wr_addr, wr_x/y/px/py write index and data
//   dbg_state            current FSM state (state_t encoding)
//
// Write handshake: wr_en is raised in WRITE with wr_addr/wr_* held stable;
// the write completes on the rising edge where wr_en and wr_ready are both 1.
// wr_en never drops before that edge and no read is issued while it is high.

module verlet_step_scheduler #(
  parameter int               WIDTH   = 32,
  parameter int               ADDR_W  = 8,
  parameter logic [WIDTH-1:0] FLOOR_Y = 32'h00F00000,
  parameter int               STEP_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_particles,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_x,
  input  logic [WIDTH-1:0]  rd_y,
  input  logic [WIDTH-1:0]  rd_px,
  input  logic [WIDTH-1:0]  rd_py,
  output logic [WIDTH-1:0]  vi_x,
  output logic [WIDTH-1:0]  vi_y,
  output logic [WIDTH-1:0]  vi_px,
  output logic [WIDTH-1:0]  vi_py,
  input  logic [WIDTH-1:0]  vi_int_x,
  input  logic [WIDTH-1:0]  vi_int_y,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_x,
  output logic [WIDTH-1:0]  wr_y,
  output logic [WIDTH-1:0]  wr_px,
  output logic [WIDTH-1:0]  wr_py,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] index_q, index_d;
  // Set when the step was started with N=0; busy then covers the DONE cycle.
  logic              zero_q, zero_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic [WIDTH-1:0]  vi_x_q, vi_x_d, vi_y_q, vi_y_d;
  logic [WIDTH-1:0]  vi_px_q, vi_px_d, vi_py_q, vi_py_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [WIDTH-1:0]  wr_px_q, wr_px_d, wr_py_q, wr_py_d;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    index_d      = index_q;
    zero_d       = zero_q;
    step_count_d = step_count_q;
    vi_x_d       = vi_x_q;
    vi_y_d       = vi_y_q;
    vi_px_d      = vi_px_q;
    vi_py_d      = vi_py_q;
    wr_addr_d    = wr_addr_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    wr_px_d      = wr_px_q;
    wr_py_d      = wr_py_q;
    busy         = 1'b0;
    done         = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = num_particles;
          index_d = '0;
          if (num_particles == '0) begin
            zero_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        vi_x_d  = rd_x;
        vi_y_d  = rd_y;
        vi_px_d = rd_px;
        vi_py_d = rd_py;
        state_d = S_CALC;
      end
      S_CALC: begin
        busy      = 1'b1;
        wr_addr_d = index_q;
        wr_x_d    = vi_int_x;
        wr_px_d   = vi_x_q;
        // Hitting the floor pins both positions, which zeroes y velocity.
        if ($signed(vi_int_y) > $signed(FLOOR_Y)) begin
          wr_y_d  = FLOOR_Y;
          wr_py_d = FLOOR_Y;
        end else begin
          wr_y_d  = vi_int_y;
          wr_py_d = vi_y_q;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (wr_ready) begin
          if (index_q == n_q - ADDR_W'(1)) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        busy         = zero_q;
        done         = 1'b1;
        zero_d       = 1'b0;
        step_count_d = step_count_q + STEP_W'(1);
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      index_q      <= '0;
      zero_q       <= 1'b0;
      step_count_q <= '0;
      vi_x_q       <= '0;
      vi_y_q       <= '0;
      vi_px_q      <= '0;
      vi_py_q      <= '0;
      wr_addr_q    <= '0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wr_px_q      <= '0;
      wr_py_q      <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      index_q      <= index_d;
      zero_q       <= zero_d;
      step_count_q <= step_count_d;
      vi_x_q       <= vi_x_d;
      vi_y_q       <= vi_y_d;
      vi_px_q      <= vi_px_d;
      vi_py_q      <= vi_py_d;
      wr_addr_q    <= wr_addr_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      wr_px_q      <= wr_px_d;
      wr_py_q      <= wr_py_d;
    end
  end

  assign step_count = step_count_q;
  assign rd_addr    = index_q;
  assign vi_x       = vi_x_q;
  assign vi_y       = vi_y_q;
  assign vi_px      = vi_px_q;
  assign vi_py      = vi_py_q;
  assign wr_addr    = wr_addr_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_px      = wr_px_q;
  assign wr_py      = wr_py_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_verlet_step_scheduler.sv
module tb_verlet_step_scheduler;
  localparam int W  = 32;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic          start, busy, done, rd_en, wr_en, wr_ready;
  logic [AW-1:0] num_particles, rd_addr, wr_addr;
  logic [15:0]   step_count;
  logic [W-1:0]  rd_x, rd_y, rd_px, rd_py;
  logic [W-1:0]  vi_x, vi_y, vi_px, vi_py, vi_int_x, vi_int_y;
  logic [W-1:0]  wr_x, wr_y, wr_px, wr_py;
  logic [2:0]    dbg_state;

  // ---------------- wrap DUT signals (STEP_W=2) ----------------
  logic          start_w, w_busy, w_done, w_rd_en, w_wr_en;
  logic [AW-1:0] w_rd_addr, w_wr_addr;
  logic [1:0]    w_step;
  logic [W-1:0]  w_vi_x, w_vi_y, w_vi_px, w_vi_py;
  logic [W-1:0]  w_wr_x, w_wr_y, w_wr_px, w_wr_py;
  logic [2:0]    w_dbg;
  logic [W-1:0]  zero_w = '0;
  logic [AW-1:0] zero_n = '0;

  verlet_step_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_particles(num_particles),
    .busy(busy), .done(done), .step_count(step_count),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_x(rd_x), .rd_y(rd_y), .rd_px(rd_px), .rd_py(rd_py),
    .vi_x(vi_x), .vi_y(vi_y), .vi_px(vi_px), .vi_py(vi_py),
    .vi_int_x(vi_int_x), .vi_int_y(vi_int_y),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_px(wr_px), .wr_py(wr_py),
    .dbg_state(dbg_state)
  );

  verlet_step_scheduler #(.STEP_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .num_particles(zero_n),
    .busy(w_busy), .done(w_done), .step_count(w_step),
    .rd_en(w_rd_en), .rd_addr(w_rd_addr),
    .rd_x(zero_w), .rd_y(zero_w), .rd_px(zero_w), .rd_py(zero_w),
    .vi_x(w_vi_x), .vi_y(w_vi_y), .vi_px(w_vi_px), .vi_py(w_vi_py),
    .vi_int_x(zero_w), .vi_int_y(zero_w),
    .wr_en(w_wr_en), .wr_ready(1'b1), .wr_addr(w_wr_addr),
    .wr_x(w_wr_x), .wr_y(w_wr_y), .wr_px(w_wr_px), .wr_py(w_wr_py),
    .dbg_state(w_dbg)
  );

  // ---------------- environment models ----------------
  logic [W-1:0] mem_x [256];
  logic [W-1:0] mem_y [256];
  logic [W-1:0] mem_px[256];
  logic [W-1:0] mem_py[256];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_x  <= mem_x[rd_addr];
      rd_y  <= mem_y[rd_addr];
      rd_px <= mem_px[rd_addr];
      rd_py <= mem_py[rd_addr];
    end
  end

  // Integrator: 2*cur - prev + accel, gravity 0x333 on y only.
  assign vi_int_x = (vi_x << 1) - vi_px;
  assign vi_int_y = (vi_y << 1) - vi_py + 32'h0000_0333;

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [135:0] exp_q[$];
  int overlap_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, stable_cnt = 0;
  logic         stall_hold = 1'b0;
  logic [135:0] held;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] px, input logic [W-1:0] py);
    exp_q.push_back({a, x, y, px, py});
  endtask

  // Samples late in the low phase, after the drivers have settled at negedge.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      stall_hold = 1'b0;
    end else begin
      if (rd_en && wr_en) overlap_cnt++;
      if (rd_en) rd_cnt++;
      if (wr_en) wr_cnt++;
      if (done) done_cnt++;
      if (stall_hold && wr_en) begin
        chk("wr_stable_in_stall", {wr_addr, wr_x, wr_y, wr_px, wr_py}, held);
        stable_cnt++;
      end
      stall_hold = wr_en && !wr_ready;
      held = {wr_addr, wr_x, wr_y, wr_px, wr_py};
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL write_unexpected: addr %0h data %0h %0h %0h %0h, none required",
                   wr_addr, wr_x, wr_y, wr_px, wr_py);
        end else begin
          chk("write", {wr_addr, wr_x, wr_y, wr_px, wr_py}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [W-1:0] x, y, px, py;
    logic [W-1:0] ex, ey, epx, epy;
  } vec_t;
  vec_t vt[5];

  // ---------------- driver ----------------
  task automatic run_step(input int n, input int exp_lat, input int stall_addr,
                          input bit inject, input string tag);
    int lat = 0;
    int stalls = 0;
    int done0 = done_cnt;
    @(negedge clk);
    num_particles = n[AW-1:0];
    start = 1'b1;
    wr_ready = 1'b1;
    while (1) begin
      @(negedge clk);
      lat++;
      start = inject && (lat == 3);
      if (inject && lat == 3) num_particles = 8'd7;
      wr_ready = 1'b1;
      if (stall_addr >= 0 && wr_en && wr_addr == stall_addr[AW-1:0] && stalls < 2) begin
        wr_ready = 1'b0;
        stalls++;
      end
      if (done || lat >= 400) break;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    chk({tag, "_done_latency"}, lat, exp_lat);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - done0, 1);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  int exp_wrap[5] = '{1, 2, 3, 0, 1};

  initial begin
    int found;
    int d0, r0, w0, s0;

    vt[0] = '{32'h00010000, 32'h00020000, 32'h0000F000, 32'h00020000,
              32'h00011000, 32'h00020333, 32'h00010000, 32'h00020000};
    vt[1] = '{32'h00010000, 32'h00EFFF00, 32'h00010000, 32'h00EFF000,
              32'h00010000, 32'h00F00000, 32'h00010000, 32'h00F00000};
    vt[2] = '{32'hFFFF0000, 32'h00EFFCCD, 32'hFFFE0000, 32'h00EFFCCD,
              32'h00000000, 32'h00F00000, 32'hFFFF0000, 32'h00EFFCCD};
    vt[3] = '{32'h7FFF0000, 32'h80001000, 32'h7FFF0000, 32'h80001000,
              32'h7FFF0000, 32'h80001333, 32'h7FFF0000, 32'h80001000};
    vt[4] = '{32'h00000100, 32'h00EFFCCE, 32'h00000200, 32'h00EFFCCE,
              32'h00000000, 32'h00F00000, 32'h00000100, 32'h00F00000};

    for (int i = 0; i < 256; i++) begin
      mem_x[i] = '0; mem_y[i] = '0; mem_px[i] = '0; mem_py[i] = '0;
    end

    rst_n = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    num_particles = '0;
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_addrs", {rd_addr, wr_addr}, 0);
    chk("rst_data", {wr_x, wr_y, wr_px, wr_py}, 0);
    chk("rst_vi", {vi_x, vi_y, vi_px, vi_py}, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single particle
    mem_x[0] = vt[0].x; mem_y[0] = vt[0].y; mem_px[0] = vt[0].px; mem_py[0] = vt[0].py;
    push_exp(0, vt[0].ex, vt[0].ey, vt[0].epx, vt[0].epy);
    run_step(1, 5, -1, 0, "single");
    chk("single_step_count", step_count, 1);

    // Table of vectors in one step, including the clamp boundaries
    for (int i = 0; i < 5; i++) begin
      mem_x[i] = vt[i].x; mem_y[i] = vt[i].y; mem_px[i] = vt[i].px; mem_py[i] = vt[i].py;
      push_exp(i[AW-1:0], vt[i].ex, vt[i].ey, vt[i].epx, vt[i].epy);
    end
    run_step(5, 21, -1, 0, "table");
    chk("table_step_count", step_count, 2);

    // N=3, particle 1 stalled two cycles, a start pulsed while busy
    for (int i = 0; i < 3; i++) push_exp(i[AW-1:0], vt[i].ex, vt[i].ey, vt[i].epx, vt[i].epy);
    s0 = stable_cnt;
    run_step(3, 15, 1, 1, "stall");
    chk("stall_stable_cycles", stable_cnt - s0, 2);
    chk("stall_step_count", step_count, 3);

    // N=0, with a start coincident with DONE
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    @(negedge clk);
    num_particles = '0;
    start = 1'b1;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy_in_done", busy, 1);
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_after", done, 0);
    chk("zero_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    chk("zero_done_pulses", done_cnt - d0, 1);
    chk("zero_no_rd", rd_cnt - r0, 0);
    chk("zero_no_wr", wr_cnt - w0, 0);
    chk("zero_step_count", step_count, 4);

    // Reset during WRITE of particle 1 (N=4)
    push_exp(0, vt[0].ex, vt[0].ey, vt[0].epx, vt[0].epy);
    @(negedge clk);
    num_particles = 8'd4;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      wr_ready = !(wr_en && wr_addr == 8'd1);
      if (wr_en && wr_addr == 8'd1) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid_reached_write1", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_step_count", step_count, 0);
    chk("rst_mid_state", dbg_state, 0);
    chk("rst_mid_writes_left", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    push_exp(0, vt[0].ex, vt[0].ey, vt[0].epx, vt[0].epy);
    run_step(1, 5, -1, 0, "restart");
    chk("restart_step_count", step_count, 1);

    // step_count wrap on the STEP_W=2 instance
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start_w = 1'b1;
      @(negedge clk);
      start_w = 1'b0;
      @(negedge clk);
      chk($sformatf("wrap_step_%0d", k), w_step, exp_wrap[k]);
    end

    chk("no_rd_wr_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/verlet_step_scheduler.md
Name: verlet_step_scheduler

Overview:
Sequences one simulation step over all particles through the shared combinational Verlet integration unit. Each particle is handled in turn:
- read current and previous position from particle RAM,
- drive the integrator,
- register its result, applying a floor clamp,
- write back with the previous position set to the old current position and the current position set to the integrated value.

The block sits between the step-control logic (start/done) and the particle RAM write port, which is gated by an arbiter ready signal.

Parameters:
- WIDTH, 32, coordinate width; two's-complement fixed point, same format as the integrator.
- ADDR_W, 8, particle index/address width; max 2^ADDR_W-1 particles.
- FLOOR_Y, 32'h00F00000, signed y limit; y grows downward because gravity is added.
- STEP_W, 16, width of step counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run one step; ignored while busy.
- num_particles  in  ADDR_W  particle count, sampled on accepted start.
- busy  out  1  step in progress.
- done  out  1  one-cycle pulse at step completion.
- step_count  out  STEP_W  completed steps, wraps modulo 2^STEP_W.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  read index.
- rd_x, rd_y, rd_px, rd_py  in  WIDTH each  RAM data, valid exactly 1 cycle after rd_en.
- vi_x, vi_y, vi_px, vi_py  out  WIDTH each  registered operands to integrator.
- vi_int_x, vi_int_y  in  WIDTH each  integrator results (combinational from vi_*).
- wr_en  out  1  write request.
- wr_ready  in  1  arbiter grant; write completes on cycle where wr_en & wr_ready.
- wr_addr  out  ADDR_W  write index.
- wr_x, wr_y, wr_px, wr_py  out  WIDTH each  write data.

Behaviour:
Reset:
- rst_n low immediately forces state IDLE.
- Outputs return to: busy=0, done=0, rd_en=0, wr_en=0, step_count=0, index=0, all data/address registers 0.
- Applies mid-step too: the write in flight is abandoned and the step is not counted.

State machine:
- IDLE: on start, latch N=num_particles and set index=0. If N=0, go to DONE; else go to READ.
- READ (1 cycle): rd_en=1, rd_addr=index. Go to LOAD.
- LOAD (1 cycle): register rd_* into vi_*. Go to CALC.
- CALC (1 cycle): register the write data:
  - wr_x = vi_int_x, wr_px = vi_x.
  - If signed vi_int_y > signed FLOOR_Y: wr_y = wr_py = FLOOR_Y (velocity killed).
  - Else: wr_y = vi_int_y, wr_py = vi_y.
  - wr_addr = index. Go to WRITE.
- WRITE: wr_en=1 with data held stable until wr_ready.
  - On accept: if index==N-1, go to DONE; else index+1 and go to READ.
  - Without wr_ready: stay in WRITE, no timeout.
- DONE (1 cycle): done=1, step_count+1, busy=0. Go to IDLE.

Timing and handshake rules:
- busy=1 in READ, LOAD, CALC and WRITE, and in the cycle when an N=0 start enters DONE.
- Throughput is 4 cycles per particle with wr_ready=1.
- done pulses 4N+1 cycles after the start cycle (1 cycle for N=0).
- start in any state other than IDLE is ignored.
- start coincident with DONE is ignored.
- Single write port: never more than one wr_en per particle, and rd_en is never asserted in the same cycle as wr_en.
- Arithmetic is the integrator's; this block adds no rounding.
- Clamp comparison is signed at WIDTH bits.
- num_particles changes during busy have no effect.

Test Plan:
- Single particle, N=1, wr_ready=1. Setup: x=0x00010000, px=0x0000F000, y=py=0x00020000, integrator model adds gravity 0x333. Required: one write to addr 0 with wr_x=0x00011000, wr_px=0x00010000, wr_y=0x00020333, wr_py=0x00020000; done 5 cycles after start; step_count=1.
- Floor clamp: y=0x00EFFF00, py=0x00EFF000, so the integrated value is 0x00F01133. Required: wr_y=wr_py=0x00F00000, x path unaffected.
- N=3 with wr_ready held low 2 cycles on particle 1. Required: writes to addrs 0,1,2 in order; wr_* stable during the stall; done at cycle 15; no rd_en overlapping wr_en.
- N=0 start. Required: no rd_en/wr_en; done 1 cycle later; step_count increments. Also a start pulsed while busy is ignored, so exactly one done occurs.
- rst_n asserted while in WRITE of particle 1 (N=4). Required: wr_en/busy drop asynchronously and step_count stays 0. A fresh start then restarts from addr 0.
- step_count wrap: with STEP_W=2, run 5 steps. Required: step_count reads 1,2,3,0,1.
